// File: rtl/quadrant_to_pos.sv
// Walks every pixel of one 64x48 cell of the 10x10 playfield grid in raster order.
// One request in, 3072 registered pixel beats out, then a done pulse.
module quadrant_to_pos #(
    parameter int CELL_W = 64,
    parameter int CELL_H = 48,
    parameter int GRID_N = 10
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] cell_x,
    input  logic [3:0] cell_y,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       pix_last,
    output logic       done,
    output logic       err
);

    localparam logic [3:0] GRID_LIM = 4'(GRID_N);
    localparam logic [5:0] LAST_X   = 6'(CELL_W - 1);
    localparam logic [5:0] LAST_Y   = 6'(CELL_H - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] base_x_q, base_x_d;
    logic [9:0] base_y_q, base_y_d;
    logic [5:0] off_x_q, off_x_d;
    logic [5:0] off_y_q, off_y_d;
    logic [9:0] pos_x_q, pos_x_d;
    logic [9:0] pos_y_q, pos_y_d;
    logic       pix_last_q, pix_last_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            base_x_q   <= '0;
            base_y_q   <= '0;
            off_x_q    <= '0;
            off_y_q    <= '0;
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            pix_last_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_x_q   <= base_x_d;
            base_y_q   <= base_y_d;
            off_x_q    <= off_x_d;
            off_y_q    <= off_y_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            pix_last_q <= pix_last_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        base_x_d = base_x_q;
        base_y_d = base_y_q;
        off_x_d  = off_x_q;
        off_y_d  = off_y_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (cell_x < GRID_LIM && cell_y < GRID_LIM) begin
                        state_d  = SCAN;
                        // cell_y picks the column band, cell_x the row band
                        base_x_d = {cell_y, 6'd0};
                        base_y_d = 10'({cell_x, 5'd0}) + 10'({cell_x, 4'd0});
                        off_x_d  = '0;
                        off_y_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (pix_ready) begin
                    if (off_x_q == LAST_X) begin
                        off_x_d = '0;
                        if (off_y_q == LAST_Y) begin
                            off_y_d = '0;
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            off_y_d = off_y_q + 6'd1;
                        end
                    end else begin
                        off_x_d = off_x_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Coordinates are precomputed from next-state so the outputs come straight from flops
        pos_x_d    = base_x_d + {4'd0, off_x_d};
        pos_y_d    = base_y_d + {4'd0, off_y_d};
        pix_last_d = (state_d == SCAN) && (off_x_d == LAST_X) && (off_y_d == LAST_Y);
    end

    assign req_ready = (state_q == IDLE);
    assign pix_valid = (state_q == SCAN);
    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign pix_last  = pix_last_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
